// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Round-robin arbiter with a bounded burst that shares one
//               single-port data RAM between the processor data port (m0)
//               and the image DMA engine (m1). Read data returns tagged to
//               the issuing master after RD_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);
  localparam logic [3:0] c_cnt_max   = 4'hf;

  logic              r_owner;     // last granted master (0 = m0, 1 = m1)
  logic [3:0]        r_cnt;       // consecutive accepts by r_owner
  logic [RD_LAT-1:0] r_pipe_vld;  // read-return pipeline valid bits
  logic [RD_LAT-1:0] r_pipe_id;   // read-return pipeline master ids

  logic w_sel;        // selected master when any request is present
  logic w_accept;     // a transfer is accepted at the next edge
  logic w_sel_we;     // write flag of the selected master
  logic w_rd_accept;  // the accepted transfer is a read

  // Select a master: single requester always wins, ties follow owner until its burst is spent
  always_comb begin
    w_sel = 1'b0;
    if (m0_req && m1_req) begin
      w_sel = (r_cnt < c_max_burst) ? r_owner : ~r_owner;
    end else if (m1_req) begin
      w_sel = 1'b1;
    end
  end

  // Grants are held low while reset is asserted so nothing is accepted during reset
  assign w_accept    = reset & (m0_req | m1_req);
  assign w_sel_we    = w_sel ? m1_we : m0_we;
  assign w_rd_accept = w_accept & ~w_sel_we;

  assign m0_gnt    = w_accept & ~w_sel;
  assign m1_gnt    = w_accept &  w_sel;

  // With no selection the address defaults to m0 and the write enable is low
  assign mem_addr  = (w_accept & w_sel) ? m1_addr  : m0_addr;
  assign mem_wdata = (w_accept & w_sel) ? m1_wdata : m0_wdata;
  assign mem_we    = w_accept & w_sel_we;

  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = r_pipe_vld[RD_LAT-1] & ~r_pipe_id[RD_LAT-1];
  assign m1_rvalid = r_pipe_vld[RD_LAT-1] &  r_pipe_id[RD_LAT-1];

  // Track the burst owner and its saturating run length; an idle cycle ends the run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (w_accept) begin
      if (w_sel == r_owner) begin
        r_cnt <= (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 4'd1;
      end else begin
        r_owner <= w_sel;
        r_cnt   <= 4'd1;
      end
    end else begin
      r_cnt <= 4'd0;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_pipe_single
      // Single-stage read return: capture the accepted read's id
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pipe_vld <= '0;
          r_pipe_id  <= '0;
        end else begin
          r_pipe_vld <= w_rd_accept;
          r_pipe_id  <= w_sel;
        end
      end
    end else begin : g_pipe_multi
      // Multi-stage read return: shift {valid, id} toward the output stage
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_pipe_vld <= '0;
          r_pipe_id  <= '0;
        end else begin
          r_pipe_vld <= {r_pipe_vld[RD_LAT-2:0], w_rd_accept};
          r_pipe_id  <= {r_pipe_id[RD_LAT-2:0], w_sel};
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench for data_mem_arbiter (RD_LAT = 2,
//               MAX_BURST = 4) with a two-stage RAM model returning addr*3
//               for unwritten locations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_pass = 0;
  int n_total = 0;

  data_mem_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: two-cycle read latency, unwritten words read as addr*3
  logic [31:0] ram [logic [31:0]];
  logic [31:0] q1 = '0, q2 = '0;
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a * 32'd3;
  endfunction
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
    q1 <= ram_rd(mem_addr);
    q2 <= q1;
  end
  assign mem_rdata = q2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  typedef struct {
    logic        r0, w0; logic [31:0] a0;
    logic        r1, w1; logic [31:0] a1;
    logic        g0, g1, we; logic [31:0] addr;
    logic        rv0, rv1; logic [31:0] rd;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                              input logic r1, input logic w1, input logic [31:0] a1,
                              input logic g0, input logic g1, input logic we, input logic [31:0] addr,
                              input logic rv0, input logic rv1, input logic [31:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.we = we; v.addr = addr; v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
    return v;
  endfunction

  initial begin
    int m1_rv_seen;
    int we_cycles;

    // Burst sequence: both read every cycle, grants rotate every 4 accepts
    tbl[0]  = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 0,0,32'h0);
    tbl[1]  = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 0,0,32'h0);
    tbl[2]  = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 1,0,32'h30);
    tbl[3]  = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 1,0,32'h30);
    tbl[4]  = mk(1,0,32'h10, 1,0,32'h20, 0,1,0,32'h20, 1,0,32'h30);
    tbl[5]  = mk(1,0,32'h10, 1,0,32'h20, 0,1,0,32'h20, 1,0,32'h30);
    tbl[6]  = mk(1,0,32'h10, 1,0,32'h20, 0,1,0,32'h20, 0,1,32'h60);
    tbl[7]  = mk(1,0,32'h10, 1,0,32'h20, 0,1,0,32'h20, 0,1,32'h60);
    tbl[8]  = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 0,1,32'h60);
    tbl[9]  = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 0,1,32'h60);
    tbl[10] = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 1,0,32'h30);
    tbl[11] = mk(1,0,32'h10, 1,0,32'h20, 1,0,0,32'h10, 1,0,32'h30);
    // Idle: no grant, address defaults to m0, last reads drain
    tbl[12] = mk(0,0,32'h99, 0,0,32'h77, 0,0,0,32'h99, 1,0,32'h30);
    tbl[13] = mk(0,0,32'h99, 0,0,32'h77, 0,0,0,32'h99, 1,0,32'h30);
    tbl[14] = mk(0,0,32'h99, 0,0,32'h77, 0,0,0,32'h99, 0,0,32'h0);
    // Writes: tie to owner m0, single m1, then tie stays with new owner m1
    tbl[15] = mk(1,1,32'h100, 1,1,32'h200, 1,0,1,32'h100, 0,0,32'h0);
    tbl[16] = mk(0,0,32'h100, 1,1,32'h204, 0,1,1,32'h204, 0,0,32'h0);
    tbl[17] = mk(1,1,32'h108, 1,1,32'h208, 0,1,1,32'h208, 0,0,32'h0);
    tbl[18] = mk(0,0,32'h99, 0,0,32'h77, 0,0,0,32'h99, 0,0,32'h0);

    // Reset state: grants forced low even with both requesting
    drive(1,0,32'h10,32'h0, 1,0,32'h20,32'h0);
    #12;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, 32'hA000_0000 | tbl[i].a0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, 32'hB000_0000 | tbl[i].a1);
      #1;
      chk($sformatf("v%0d_m0_gnt", i), 32'(m0_gnt), 32'(tbl[i].g0));
      chk($sformatf("v%0d_m1_gnt", i), 32'(m1_gnt), 32'(tbl[i].g1));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(tbl[i].rv0));
      chk($sformatf("v%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(tbl[i].rv1));
      if (tbl[i].rv0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, tbl[i].rd);
      if (tbl[i].rv1) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, tbl[i].rd);
      if (tbl[i].we)
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata,
            (tbl[i].g1 ? 32'hB000_0000 : 32'hA000_0000) | tbl[i].addr);
      tick();
    end

    // Lone m1 for 17 cycles: always granted, run length saturates at 15
    for (int i = 0; i < 17; i++) begin
      drive(0,0,32'h0,32'h0, 1,0,32'h300 + 32'(i),32'h0);
      #1;
      chk($sformatf("solo%0d_m1_gnt", i), {30'd0, m0_gnt, m1_gnt}, 32'd1);
      tick();
    end
    // Saturated count (15 >= 4) must hand the tie to m0; a wrapped count would not
    drive(1,0,32'h10,32'h0, 1,0,32'h20,32'h0);
    #1;
    chk("sat_tie_m0_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    tick();
    drive(0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
    repeat (3) tick();

    // RD_LAT=2 tagging: m0 reads 0x4 at edge k, m1 reads 0x8 at edge k+1
    drive(1,0,32'h4,32'h0, 0,0,32'h0,32'h0);
    #1; chk("lat_m0_gnt", 32'(m0_gnt), 32'd1);
    tick();
    drive(0,0,32'h0,32'h0, 1,0,32'h8,32'h0);
    #1;
    chk("lat_m1_gnt", 32'(m1_gnt), 32'd1);
    chk("lat_early_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();
    drive(0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
    #1;
    chk("lat_m0_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
    chk("lat_m0_rdata", m0_rdata, 32'd12);
    tick();
    #1;
    chk("lat_m1_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd2);
    chk("lat_m1_rdata", m1_rdata, 32'd24);
    tick();

    // Write then read back the same word
    we_cycles = 0;
    drive(1,1,32'h40,32'hDEADBEEF, 0,0,32'h0,32'h0);
    #1;
    if (mem_we) we_cycles++;
    chk("wr_mem_addr", mem_addr, 32'h40);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    drive(1,0,32'h40,32'h0, 0,0,32'h0,32'h0);
    #1;
    if (mem_we) we_cycles++;
    tick();
    drive(0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
    #1;
    if (mem_we) we_cycles++;
    chk("wr_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();
    #1;
    if (mem_we) we_cycles++;
    chk("rd_back_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
    chk("rd_back_data", m0_rdata, 32'hDEADBEEF);
    chk("wr_we_cycles", 32'(we_cycles), 32'd1);
    tick();

    // Reset mid-flight: m1 read accepted, then reset before its return
    drive(0,0,32'h0,32'h0, 1,0,32'h30,32'h0);
    #1; chk("mid_m1_gnt", 32'(m1_gnt), 32'd1);
    tick();
    drive(1,1,32'h50,32'h1, 1,1,32'h60,32'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();
    tick();
    drive(0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
    reset = 1'b1;
    m1_rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m1_rvalid) m1_rv_seen++;
      tick();
    end
    chk("post_rst_m1_rv", 32'(m1_rv_seen), 32'd0);
    // Priority restarts: first tie after reset goes to m0
    drive(1,0,32'h10,32'h0, 1,0,32'h20,32'h0);
    #1;
    chk("post_rst_tie", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    tick();
    drive(0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port data RAM between the processor's data port (m0) and the image DMA engine (m1). Every cycle it selects at most one requester and drives the RAM address, write data and write enable from that requester. It returns read data tagged to the requester that issued the read. Arbitration is round-robin with a bounded burst, so neither master can starve the other. The processor treats `m0_gnt` low as a stall.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `RD_LAT`, 1, RAM read latency in cycles. Legal range is 1..4.
- `MAX_BURST`, 4, maximum number of consecutive accepted transfers for one master while the other master is requesting. Legal range is 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  transfer request; held until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  AW  word address.
- `m0_wdata`, `m1_wdata`  in  DW  write data.
- `m0_gnt`, `m1_gnt`  out  1  combinational grant; transfer accepted at the edge where req & gnt.
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid for that master.
- `m0_rdata`, `m1_rdata`  out  DW  both driven from `mem_rdata`; meaningful only with rvalid.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM read data, valid RD_LAT cycles after address.

## Operation
- State:
  - `owner` (1 bit): last granted master.
  - `cnt` (4 bits): consecutive accepted transfers by `owner`.
  - `rd_pipe`: RD_LAT stages of {valid, id}.
- Select, computed combinationally each cycle:
  - Only m0 requesting: select m0.
  - Only m1 requesting: select m1.
  - Both requesting: select `owner` if cnt < MAX_BURST, else select the other master.
  - Neither requesting: no selection.
- Grant and RAM drive:
  - Exactly one gnt high when any request is present; both low otherwise.
  - `mem_addr`, `mem_wdata` and `mem_we` follow the selected master.
  - With no selection: `mem_we` = 0, `mem_addr` = `m0_addr`.
- On an accepted transfer:
  - Selected master equal to `owner`: cnt <= cnt + 1, saturating at 15.
  - Otherwise: owner <= selected master, cnt <= 1.
- Idle cycle (no request): owner unchanged, cnt <= 0.
- A single requester is never blocked; the burst limit applies only while both masters request.
- Accepted read: push {1, id} into `rd_pipe`. Writes and idle cycles push {0, x}.
- Pipe output drives `mN_rvalid` for the matching id; at most one rvalid is high per cycle.
- `mN_rdata` = `mem_rdata` for both masters at all times.
- Writes produce no response; the write completes at the accepting edge.

## Timing
- Reset (`reset` = 0), asynchronous:
  - owner = 0, cnt = 0, all `rd_pipe` valids = 0.
  - Outputs: `m0_gnt` = `m1_gnt` = 0, `mem_we` = 0, `m0_rvalid` = `m1_rvalid` = 0.
  - Grants are forced low while reset is low, regardless of req.
- After reset, the first tie is won by m0 (owner = 0, cnt = 0 < MAX_BURST).
- Grant latency: 0 cycles, same cycle as req when selected.
- Read latency: a read accepted at edge k gives rvalid and rdata during the cycle following edge k+RD_LAT−1. For RD_LAT = 1 that is the cycle right after acceptance.
- Throughput: one transfer per cycle. Back-to-back reads from alternating masters return in issue order with correct ids.
- Simultaneous events in one cycle:
  - A new grant can coincide with an rvalid for the other master; both are legal.
  - The count saturation and the switch decision both use the pre-edge cnt.
- Reset mid-operation: in-flight reads are discarded and no rvalid appears after reset release. The owner and priority state restart as after power-up.
- Deasserting req without a grant withdraws the request; no transfer occurs.

## Test plan
- Reset, then m0 and m1 both request reads at 0x10 and 0x20 in the same cycle. Required: `m0_gnt` = 1 and `m1_gnt` = 0 in cycle 0; `m1_gnt` = 1 in cycle 1 only if m0 has dropped req.
- Both masters request continuously with MAX_BURST = 4. Required: m0 granted in cycles 0–3, m1 in cycles 4–7, m0 in cycles 8–11; no master is granted more than 4 consecutive cycles.
- Only m1 requests for 20 cycles. Required: `m1_gnt` = 1 in every cycle and cnt saturates at 15 without wrapping.
- RD_LAT = 2, m0 reads 0x4 at edge k and m1 reads 0x8 at edge k+1, with the RAM model returning addr×3. Required: `m0_rvalid` with `m0_rdata` = 12 after edge k+1; `m1_rvalid` with `m1_rdata` = 24 after edge k+2.
- m0 writes 0xDEADBEEF to 0x40, then reads 0x40. Required: `mem_we` = 1 for exactly one cycle, no rvalid for the write, and the read returns 0xDEADBEEF.
- m1 read accepted, then `reset` pulled low before rvalid. Required: all outputs are 0 immediately, and no `m1_rvalid` appears after release.
